muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit that consumes the two operands produced by the register file read ports (`out1`, `out2`) and returns a 64-bit result split into `hi`/`lo` for writeback. It runs alongside the single-cycle ALU: the controller pulses `start`, stalls while `busy` is high, and writes `hi`/`lo` when `done` pulses. Each operation takes WIDTH+1 cycles: WIDTH shift-add or restore-subtract iterations plus one sign-fixup cycle. Divide-by-zero completes early.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the pipeline controller and muldiv_unit.
// The controller side drives the request; the unit side returns status and the hi/lo result.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, opa, opb,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: WIDTH shift-add or restoring-subtract steps on magnitudes,
// then one cycle of sign fixup. Divide by zero short-circuits straight to DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [DW-1:0]    acc_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] addend_r;
  logic             op_div_r;
  logic             neg_p_r;
  logic             neg_r_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             accept_s;
  logic             dbz_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic             rem_ge_s;
  logic [WIDTH-1:0] rem_diff_s;
  logic [DW-1:0]    acc_next_s;
  logic [WIDTH-1:0] shift_next_s;
  logic [DW-1:0]    prod_s;
  logic [WIDTH-1:0] fix_hi_s;
  logic [WIDTH-1:0] fix_lo_s;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

  // Request decode: signs only matter for the signed ops, magnitudes feed the datapath.
  always_comb begin
    sign_a_s = bus.op[0] & bus.opa[WIDTH-1];
    sign_b_s = bus.op[0] & bus.opb[WIDTH-1];
    mag_a_s  = cneg(bus.opa, sign_a_s);
    mag_b_s  = cneg(bus.opb, sign_b_s);
    accept_s = bus.start & ((state_r == IDLE) | (state_r == DONE));
    dbz_s    = bus.op[1] & (bus.opb == {WIDTH{1'b0}});
  end

  // One iteration: right-shift/add for multiply, shift/trial-subtract for divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[DW-1:WIDTH]} + {1'b0, (shift_r[0] ? addend_r : {WIDTH{1'b0}})};
    rem_sh_s   = {acc_r[DW-1:WIDTH], shift_r[WIDTH-1]};
    rem_ge_s   = (rem_sh_s >= {1'b0, addend_r});
    // The true difference is below the divisor, so modulo-2^WIDTH arithmetic is exact.
    rem_diff_s = rem_sh_s[WIDTH-1:0] - addend_r;
    if (op_div_r) begin
      if (rem_ge_s) begin
        acc_next_s = {rem_diff_s, acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
      shift_next_s = {shift_r[WIDTH-2:0], 1'b0};
    end else begin
      acc_next_s   = {mul_sum_s, acc_r[WIDTH-1:1]};
      shift_next_s = {1'b0, shift_r[WIDTH-1:1]};
    end
  end

  // Sign fixup: full-width negate for the product, separate negates for quotient/remainder.
  always_comb begin
    if (neg_p_r) begin
      prod_s = ~acc_r + DW'(1);
    end else begin
      prod_s = acc_r;
    end
    if (op_div_r) begin
      fix_hi_s = cneg(acc_r[DW-1:WIDTH], neg_r_r);
      fix_lo_s = cneg(acc_r[WIDTH-1:0], neg_p_r);
    end else begin
      fix_hi_s = prod_s[DW-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {DW{1'b0}};
      shift_r  <= {WIDTH{1'b0}};
      addend_r <= {WIDTH{1'b0}};
      op_div_r <= 1'b0;
      neg_p_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            op_div_r <= bus.op[1];
            if (dbz_s) begin
              state_r <= DONE;
              hi_r    <= bus.opa;
              lo_r    <= {WIDTH{1'b1}};
              dbz_r   <= 1'b1;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r  <= CALC;
              cnt_r    <= CW'(WIDTH);
              acc_r    <= {DW{1'b0}};
              shift_r  <= bus.op[1] ? mag_a_s : mag_b_s;
              addend_r <= bus.op[1] ? mag_b_s : mag_a_s;
              neg_p_r  <= sign_a_s ^ sign_b_s;
              neg_r_r  <= sign_a_s;
              dbz_r    <= 1'b0;
              busy_r   <= 1'b1;
              done_r   <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            done_r  <= 1'b0;
          end
        end
        CALC: begin
          acc_r   <= acc_next_s;
          shift_r <= shift_next_s;
          cnt_r   <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed products, quotients, timing and reset behaviour.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for exactly one edge (edge 0), then drop start.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; returns edges waited and busy cycles seen (including the current one).
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      tick();
      edges++;
      if (bus.busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.opa = 32'h0; bus.opb = 32'h0;
    reset = 1'b1;
    tick(); tick();
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests_run++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin tests_failed++; $display("FAIL reset_hilo: got %h_%h expected 0_0", bus.hi, bus.lo); end
    tests_run++; if (bus.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_multu();
    int edges, bc;
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(edges, bc);
    tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL multu_latency: got %0d edges expected 33", edges); end
    tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    tests_run++; if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin tests_failed++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", bus.hi, bus.lo); end
    tick();
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL multu_done_pulse: got %b expected 0", bus.done); end
    tests_run++; if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin tests_failed++; $display("FAIL multu_hold: got %h_%h expected fffffffe_00000001", bus.hi, bus.lo); end
  endtask

  task automatic test_back_to_back();
    int edges, bc;
    launch(2'b01, 32'hFFFFFFFD, 32'h00000007);
    wait_done(edges, bc);
    tests_run++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin tests_failed++; $display("FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", bus.hi, bus.lo); end
    // Now sitting in DONE; keep start high so the DONE edge becomes the new edge 0.
    launch(2'b00, 32'h00000003, 32'h00000007);
    tests_run++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
    wait_done(edges, bc);
    tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL b2b_latency: got %0d edges expected 33", edges); end
    tests_run++; if (bus.hi !== 32'h0 || bus.lo !== 32'd21) begin tests_failed++; $display("FAIL b2b_result: got %h_%h expected 00000000_00000015", bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_divide();
    int edges, bc;
    launch(2'b11, 32'hFFFFFFF9, 32'h00000002);
    wait_done(edges, bc);
    tests_run++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL div_neg7_2: got q=%h r=%h expected q=fffffffd r=ffffffff", bus.lo, bus.hi); end
    tick();
    launch(2'b10, 32'd100, 32'd7);
    wait_done(edges, bc);
    tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL divu_latency: got %0d edges expected 33", edges); end
    tests_run++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin tests_failed++; $display("FAIL divu_100_7: got q=%h r=%h expected q=0000000e r=00000002", bus.lo, bus.hi); end
    tick();
    launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done(edges, bc);
    tests_run++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0 || bus.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL div_minint: got q=%h r=%h dbz=%b expected q=80000000 r=0 dbz=0", bus.lo, bus.hi, bus.div_by_zero); end
    tick();
  endtask

  task automatic test_div_by_zero();
    int edges, bc;
    launch(2'b10, 32'd5, 32'd0);
    tests_run++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL dbz_latency: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
    tests_run++; if (bus.div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag: got %b expected 1", bus.div_by_zero); end
    tests_run++; if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL dbz_result: got %h_%h expected 00000005_ffffffff", bus.hi, bus.lo); end
    tick();
    tests_run++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_hold: got done=%b dbz=%b expected done=0 dbz=1", bus.done, bus.div_by_zero); end
    launch(2'b00, 32'd2, 32'd3);
    tests_run++; if (bus.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL dbz_clear: got %b expected 0", bus.div_by_zero); end
    wait_done(edges, bc);
    tests_run++; if (bus.lo !== 32'd6 || bus.hi !== 32'd0) begin tests_failed++; $display("FAIL dbz_next_mul: got %h_%h expected 00000000_00000006", bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_ignore_start();
    int edges, bc;
    launch(2'b00, 32'h00010001, 32'h00010001);
    tick(); tick(); tick(); tick();
    launch(2'b10, 32'd100, 32'd7);
    bus.opa = 32'hDEADBEEF;
    bus.opb = 32'h00000000;
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL ignore_busy: got %b expected 1", bus.busy); end
    wait_done(edges, bc);
    tests_run++; if (edges !== 28) begin tests_failed++; $display("FAIL ignore_latency: got %0d edges expected 28", edges); end
    tests_run++; if (bus.hi !== 32'h00000001 || bus.lo !== 32'h00020001) begin tests_failed++; $display("FAIL ignore_result: got %h_%h expected 00000001_00020001", bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int edges, bc;
    launch(2'b01, 32'hFFFFFFFD, 32'h00000007);
    repeat (9) tick();
    reset = 1'b1;
    #1;
    tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL midreset_status: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    tests_run++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL midreset_result: got %h_%h dbz=%b expected 0_0 dbz=0", bus.hi, bus.lo, bus.div_by_zero); end
    #2;
    reset = 1'b0;
    tick();
    launch(2'b10, 32'd9, 32'd4);
    wait_done(edges, bc);
    tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL postreset_latency: got %0d edges expected 33", edges); end
    tests_run++; if (bus.lo !== 32'd2 || bus.hi !== 32'd1) begin tests_failed++; $display("FAIL postreset_divu: got q=%h r=%h expected q=00000002 r=00000001", bus.lo, bus.hi); end
    tick();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_back_to_back();
    test_divide();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
